screen_drv: RTL and testbench
=============================

# screen_drv

Six-digit multiplexed 7-segment display driver for the clock.
- Sink side of the configuration-to-screen path: consumes the BCD edit value and toggle strobe produced by the configuration block, plus the running time from the inner clock.
- Run mode (conf_stat = 0): scans the live hh:mm:ss.
- Edit mode (conf_stat = 1..3): shows the edit value and blinks the field being edited.
- Drives common-anode digits: segments and digit enables are active-low.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays selected; legal ≥ 2.
- BLINK_DIV, 25000000: clock cycles per blink half-period; legal ≥ 2.

Ports:
- clk  in  1  single system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- conf_pulse  in  1  edit-update strobe; every toggle (either edge) means a new edit value
- conf_stat  in  2  0 = run, 1 = edit sec, 2 = edit min, 3 = edit h; asynchronous to clk
- h_min_sec_tracker  in  24  edit value, BCD [23:16]=h, [15:8]=min, [7:0]=sec; stable before conf_pulse toggles
- h_min_sec_live  in  24  running time, same BCD packing
- seg  out  8  [6:0] = segments g..a, [7] = dp; active-low
- an  out  6  digit enables, one-hot active-low; an[0] = sec ones … an[5] = h tens

## Operation
Synchronisers:
- conf_pulse passes through 2 flops (s1, s2), plus a history flop s3.
- Edge detect = s2 ^ s3.
- conf_stat passes through a 2-flop synchroniser; all mode decisions use the synchronised value.

Scan:
- scan_cnt counts 0..SCAN_DIV-1.
- At terminal count: scan_cnt → 0 and digit index idx advances 0→1→…→5→0.

Buffers:
- live_buf (24 b) samples h_min_sec_live on the idx 5→0 wrap only, giving tear-free frames.
- edit_buf (24 b) loads h_min_sec_tracker on each conf_pulse edge detect.

Blink:
- blink_cnt counts 0..BLINK_DIV-1; at terminal count it wraps and blink_on toggles.
- A conf_pulse edge clears blink_cnt and forces blink_on = 1 (field visible). This overrides a simultaneous terminal count.

Digit selection:
- Source = live_buf in run mode, edit_buf in edit mode.
- Nibble = source[4*idx+3 : 4*idx].

Decode (active-low, g..a):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Nibble > 9 → "-" (0111111).

Blanking:
- In edit mode with blink_on = 0, the edited field's digits are blanked (seg = 8'hFF).
- Edited field by conf_stat: 1 → idx 0–1; 2 → idx 2–3; 3 → idx 4–5.
- Other digits display normally.

Decimal point:
- dp = 0 (lit) on idx 2 and 4 in run mode; 1 (off) otherwise.

## Timing
Reset (rst_n low, asynchronous):
- seg = 8'hFF, an = 6'h3F (all dark).
- idx = 0, scan_cnt = 0, blink_cnt = 0, blink_on = 1.
- live_buf = 0, edit_buf = 0, all synchroniser flops = 0.
- Reset mid-scan or mid-blink aborts immediately; no partial state survives.

Outputs:
- seg and an are registered, one cycle behind idx and the buffers.
- First clock edge after rst_n rises: an = 6'b111110, seg = decode of digit 0 of live_buf (0 → 8'b11000000).

Conf_pulse latency:
- conf_pulse toggles before edge N → s2 changes at N+1 → edit_buf loads at N+2 → value visible on seg by N+3 if its digit is selected.

Other rules:
- A conf_pulse toggle held for less than 1 clock period is not guaranteed to be detected; the producer toggles at most once per 4 clocks.
- Mode change takes effect 2 cycles after conf_stat settles and applies to the next digit driven; no scan reset.
- Scan period is 6·SCAN_DIV cycles; idx wraps 5→0 with no idle slot.
- an never has more than one bit low; no dark gap is required between digits.

## Test plan
Use SCAN_DIV = 4, BLINK_DIV = 16.
- Reset: hold rst_n low 5 cycles → seg = FF, an = 3F. Release with live = 24'h123456, wait one full frame → an cycles 3E,3D,3B,37,2F,1F at 4 cycles each; digit 0 shows "6" (8'b10000010); dp lit only on an = 3B and 2F.
- Tear-free update: change live 24'h000059 → 24'h000100 mid-frame → displayed digits change only after the next idx 5→0 wrap.
- Edit latch: conf_stat = 2, tracker = 24'h094500, toggle conf_pulse → edit_buf = 094500 exactly 2 edges later. Digits 2–3 show 5, 4; blink_on = 1 for the next 16 cycles.
- Blink: conf_stat = 2 held, no pulses → digits 2–3 blank for 16 cycles, visible for 16, repeating. Digits 0–1 and 4–5 never blank.
- Blink restart collision: toggle conf_pulse so its edge detect coincides with blink terminal count → blink_on = 1, blink_cnt = 0.
- Invalid BCD: tracker = 24'h00A000 in edit mode → digit 3 shows "-" (8'b10111111 with dp off).

Source files
------------

// File: rtl/screen_drv_if.sv
// Signal bundle between the clock core and the 6-digit display driver.
// The master drives time and edit values; the slave drives segments and anodes.
interface screen_drv_if;
    logic        conf_pulse;
    logic [1:0]  conf_stat;
    logic [23:0] h_min_sec_tracker;
    logic [23:0] h_min_sec_live;
    logic [7:0]  seg;
    logic [5:0]  an;

    modport master (
        output conf_pulse, conf_stat, h_min_sec_tracker, h_min_sec_live,
        input  seg, an
    );

    modport slave (
        input  conf_pulse, conf_stat, h_min_sec_tracker, h_min_sec_live,
        output seg, an
    );
endinterface

// File: rtl/screen_drv.sv
// Six-digit multiplexed common-anode 7-segment driver: scans live time in run mode,
// shows the edit value with a blinking field in edit mode.
module screen_drv #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic          clk,
    input  logic          rst_n,
    screen_drv_if.slave   scr_if
);
    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic              pulse_s1_q, pulse_s2_q, pulse_s3_q;
    logic [1:0]        stat_s1_q, stat_s2_q;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [2:0]        idx_q;
    logic [23:0]       live_buf_q, edit_buf_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic              blink_on_q;
    logic [7:0]        seg_q, seg_d;
    logic [5:0]        an_q, an_d;

    logic pulse_edge;
    logic scan_tc;
    logic blink_tc;

    assign pulse_edge = pulse_s2_q ^ pulse_s3_q;
    assign scan_tc    = (scan_cnt_q == SCAN_LAST);
    assign blink_tc   = (blink_cnt_q == BLINK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_s1_q <= 1'b0;
            pulse_s2_q <= 1'b0;
            pulse_s3_q <= 1'b0;
            stat_s1_q  <= 2'd0;
            stat_s2_q  <= 2'd0;
        end else begin
            pulse_s1_q <= scr_if.conf_pulse;
            pulse_s2_q <= pulse_s1_q;
            pulse_s3_q <= pulse_s2_q;
            stat_s1_q  <= scr_if.conf_stat;
            stat_s2_q  <= stat_s1_q;
        end
    end

    // live_buf only refreshes on the 5->0 wrap so a frame never mixes two times
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= 3'd0;
            live_buf_q <= 24'd0;
        end else if (scan_tc) begin
            scan_cnt_q <= '0;
            if (idx_q == 3'd5) begin
                idx_q      <= 3'd0;
                live_buf_q <= scr_if.h_min_sec_live;
            end else begin
                idx_q <= idx_q + 3'd1;
            end
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    // A fresh edit value restarts the blink with the field visible, even on terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edit_buf_q  <= 24'd0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            if (pulse_edge) begin
                edit_buf_q  <= scr_if.h_min_sec_tracker;
                blink_cnt_q <= '0;
                blink_on_q  <= 1'b1;
            end else if (blink_tc) begin
                blink_cnt_q <= '0;
                blink_on_q  <= ~blink_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    logic        edit_mode;
    logic [23:0] src;
    logic [3:0]  nibble;
    logic [6:0]  segs;
    logic        field_hit;

    always_comb begin
        edit_mode = (stat_s2_q != 2'd0);
        src       = edit_mode ? edit_buf_q : live_buf_q;
        case (idx_q)
            3'd0:    nibble = src[3:0];
            3'd1:    nibble = src[7:4];
            3'd2:    nibble = src[11:8];
            3'd3:    nibble = src[15:12];
            3'd4:    nibble = src[19:16];
            3'd5:    nibble = src[23:20];
            default: nibble = 4'hF;
        endcase
        case (nibble)
            4'd0:    segs = 7'b1000000;
            4'd1:    segs = 7'b1111001;
            4'd2:    segs = 7'b0100100;
            4'd3:    segs = 7'b0110000;
            4'd4:    segs = 7'b0011001;
            4'd5:    segs = 7'b0010010;
            4'd6:    segs = 7'b0000010;
            4'd7:    segs = 7'b1111000;
            4'd8:    segs = 7'b0000000;
            4'd9:    segs = 7'b0010000;
            default: segs = 7'b0111111;
        endcase
        // conf_stat 1/2/3 selects digit pairs 0-1/2-3/4-5
        field_hit = edit_mode && (idx_q[2:1] == 2'(stat_s2_q - 2'd1));

        an_d = ~(6'b000001 << idx_q);
        if (field_hit && !blink_on_q) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = {~(!edit_mode && (idx_q == 3'd2 || idx_q == 3'd4)), segs};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 8'hFF;
            an_q  <= 6'h3F;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign scr_if.seg = seg_q;
    assign scr_if.an  = an_q;
endmodule

// File: tb/tb_screen_drv.sv
// Directed bench for screen_drv with SCAN_DIV=4, BLINK_DIV=16; outputs sampled on falling edges.
module tb_screen_drv;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    screen_drv_if scr ();

    screen_drv #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .scr_if (scr.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
        $fatal(1, "watchdog");
    end

    logic [5:0] exp_an  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    logic [7:0] exp_123 [6] = '{8'h82, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9};

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_out(input string name, input logic [7:0] seg_e, input logic [5:0] an_e);
        checks++;
        if (scr.seg !== seg_e || scr.an !== an_e) begin
            errors++;
            $display("FAIL %s: seg=%h an=%h required seg=%h an=%h", name, scr.seg, scr.an, seg_e, an_e);
        end else
            $display("ok   %s: seg=%h an=%h", name, scr.seg, scr.an);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        scr.conf_pulse = 1'b0;
        scr.conf_stat = 2'd0;
        scr.h_min_sec_tracker = 24'd0;
        scr.h_min_sec_live = 24'h123456;
        step(5);
        chk_out("reset_dark", 8'hFF, 6'h3F);
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        for (int d = 0; d < 6; d++) begin
            for (int c = 0; c < 4; c++) begin
                step(1);
                chk_out($sformatf("frame0_d%0d_c%0d", d, c), (d == 2 || d == 4) ? 8'h40 : 8'hC0, exp_an[d]);
            end
        end
        for (int d = 0; d < 6; d++) begin
            step(1);
            chk_out($sformatf("frame1_d%0d", d), exp_123[d], exp_an[d]);
            step(3);
        end
    endtask

    task automatic test_tear();
        scr.h_min_sec_live = 24'h000059;
        step(24);
        step(1);  chk_out("tear_059_d0", 8'h90, 6'h3E);
        step(4);  chk_out("tear_059_d1", 8'h92, 6'h3D);
        step(4);
        scr.h_min_sec_live = 24'h000100;
        step(1);  chk_out("tear_midframe_d2", 8'h40, 6'h3B);
        step(14);
        step(1);  chk_out("tear_100_d0", 8'hC0, 6'h3E);
        step(8);  chk_out("tear_100_d2", 8'h79, 6'h3B);
        step(15);
    endtask

    task automatic test_edit_blink();
        scr.conf_stat = 2'd2;
        scr.h_min_sec_tracker = 24'h094500;
        scr.conf_pulse = ~scr.conf_pulse;
        step(2);
        checks++;
        if (dut.edit_buf_q !== 24'h000000) begin
            errors++;
            $display("FAIL edit_early: edit_buf=%h required 000000", dut.edit_buf_q);
        end else $display("ok   edit_early: edit_buf=%h", dut.edit_buf_q);
        step(1);
        checks++;
        if (dut.edit_buf_q !== 24'h094500 || dut.blink_on_q !== 1'b1 || dut.blink_cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL edit_latch: edit_buf=%h blink_on=%b blink_cnt=%0d required 094500 1 0",
                     dut.edit_buf_q, dut.blink_on_q, dut.blink_cnt_q);
        end else $display("ok   edit_latch: edit_buf=%h", dut.edit_buf_q);
        step(6);  chk_out("edit_d2_visible", 8'h92, 6'h3B);
        step(4);  chk_out("edit_d3_visible", 8'h99, 6'h37);
        step(4);  chk_out("edit_d4", 8'h90, 6'h2F);
        step(4);  chk_out("edit_d5", 8'hC0, 6'h1F);
        step(12); chk_out("blink_d2_blank", 8'hFF, 6'h3B);
        step(3);  chk_out("blink_d2_back", 8'h92, 6'h3B);
        step(1);  chk_out("blink_d3_on", 8'h99, 6'h37);
        step(20); chk_out("blink2_d2_blank", 8'hFF, 6'h3B);
        step(4);  chk_out("blink2_d3_blank", 8'hFF, 6'h37);
        step(4);  chk_out("blink2_d4_never", 8'h90, 6'h2F);
        step(31);
    endtask

    task automatic test_collision_invalid();
        step(16);
        scr.h_min_sec_tracker = 24'h00A000;
        scr.conf_stat = 2'd3;
        scr.conf_pulse = ~scr.conf_pulse;
        step(2);
        checks++;
        if (dut.blink_cnt_q !== 4'd15 || dut.blink_on_q !== 1'b1) begin
            errors++;
            $display("FAIL coll_pre: blink_cnt=%0d blink_on=%b required 15 1", dut.blink_cnt_q, dut.blink_on_q);
        end else $display("ok   coll_pre: blink_cnt=%0d", dut.blink_cnt_q);
        step(1);
        checks++;
        if (dut.blink_cnt_q !== 4'd0 || dut.blink_on_q !== 1'b1 || dut.edit_buf_q !== 24'h00A000) begin
            errors++;
            $display("FAIL coll_restart: blink_cnt=%0d blink_on=%b edit_buf=%h required 0 1 00a000",
                     dut.blink_cnt_q, dut.blink_on_q, dut.edit_buf_q);
        end else $display("ok   coll_restart: blink_on=%b", dut.blink_on_q);
        step(14); chk_out("invalid_d2", 8'hC0, 6'h3B);
        step(4);  chk_out("invalid_d3_dash", 8'hBF, 6'h37);
        step(11);
    endtask

    task automatic test_run_return();
        scr.conf_stat = 2'd0;
        step(9);  chk_out("run_d2_dp", 8'h79, 6'h3B);
        step(8);  chk_out("run_d4_dp", 8'h40, 6'h2F);
    endtask

    task automatic test_midreset();
        step(2);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("midreset_dark", 8'hFF, 6'h3F);
        checks++;
        if (dut.idx_q !== 3'd0 || dut.scan_cnt_q !== 2'd0 || dut.edit_buf_q !== 24'd0 ||
            dut.live_buf_q !== 24'd0 || dut.blink_on_q !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: idx=%0d scan=%0d edit=%h live=%h blink_on=%b required 0 0 0 0 1",
                     dut.idx_q, dut.scan_cnt_q, dut.edit_buf_q, dut.live_buf_q, dut.blink_on_q);
        end else $display("ok   midreset_state: idx=%0d", dut.idx_q);
        step(1);
        rst_n = 1'b1;
        step(1);  chk_out("midreset_first", 8'hC0, 6'h3E);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear();
        test_edit_blink();
        test_collision_invalid();
        test_run_return();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
